// File: rtl/passageway_pkg.sv
// Shared types for the passageway monitor:
// door modes and error-cause codes.
package passageway_pkg;

    typedef enum logic [1:0] {
        MODE_CLOSED   = 2'd0,
        MODE_OPEN     = 2'd1,
        MODE_DOORSTEP = 2'd2
    } mode_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CLOSED   = 3'd1;
    localparam logic [2:0] ERR_OPEN     = 3'd2;
    localparam logic [2:0] ERR_DOORSTEP = 3'd3;
    localparam logic [2:0] ERR_ONEHOT   = 3'd4;
    localparam logic [2:0] ERR_DEADLINE = 3'd5;

endpackage

// File: rtl/passageway_monitor_n_if.sv
// Tester/SUT observation bundle and monitor
// verdict outputs for the passageway monitor.
interface passageway_monitor_n_if #(
    parameter int NZONES = 5,
    parameter int CW     = 8
);
    logic              iup;
    logic              iright;
    logic [NZONES-1:0] controllable_zone;
    logic              controllable_open;
    logic              controllable_doorstep;
    logic              controllable_fault;
    logic              error;
    logic              objective;
    logic [2:0]        err_code;
    logic [CW-1:0]     steps;

    modport master (
        output iup, iright, controllable_zone,
        output controllable_open, controllable_doorstep,
        output controllable_fault,
        input  error, objective, err_code, steps
    );

    modport slave (
        input  iup, iright, controllable_zone,
        input  controllable_open, controllable_doorstep,
        input  controllable_fault,
        output error, objective, err_code, steps
    );
endinterface

// File: rtl/passageway_zone_step.sv
// Next-zone selection: zone 0 always wins, else the
// lowest neighbouring zone the SUT legally moved into.
module passageway_zone_step
    import passageway_pkg::*;
#(
    parameter int NZONES = 5
) (
    input  logic [$clog2(NZONES)-1:0] zone,
    input  mode_t                     mode,
    input  logic [NZONES-1:0]         controllable_zone,
    output logic [$clog2(NZONES)-1:0] zone_next
);
    localparam int ZW = $clog2(NZONES);

    logic hit;

    always_comb begin
        zone_next = zone;
        hit       = 1'b0;
        if (controllable_zone[0]) begin
            zone_next = '0;
            hit       = 1'b1;
        end
        for (int k = 1; k < NZONES; k++) begin
            if (!hit && controllable_zone[k]) begin
                // the top zone has no zone above it to come down from
                if ((zone == ZW'(k - 1) &&
                     mode == MODE_DOORSTEP) ||
                    (k < NZONES - 1 &&
                     zone == ZW'(k + 1))) begin
                    zone_next = ZW'(k);
                    hit       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/passageway_monitor_n.sv
// Passageway monitor: tracks zone, door mode and fault,
// flags the first rule violation and the objective.
module passageway_monitor_n
    import passageway_pkg::*;
#(
    parameter int NZONES   = 5,
    parameter int TARGET   = NZONES - 1,
    parameter int DEADLINE = 0,
    parameter int CW       = 8
) (
    input logic                  clk,
    input logic                  rst,
    passageway_monitor_n_if.slave bus
);
    localparam int ZW = $clog2(NZONES);

    logic              notfirst;
    logic              fault;
    logic              err;
    logic [2:0]        code;
    logic [CW-1:0]     steps;
    logic [ZW-1:0]     zone;
    logic [ZW-1:0]     zone_next;
    mode_t             mode;
    mode_t             mode_next;
    logic [NZONES-1:0] cz;
    logic              cz_here;
    logic              cz_up;
    logic              below_top;
    logic              ileft;
    logic              objective;
    logic              v_onehot;
    logic              v_closed;
    logic              v_open;
    logic              v_door;
    logic              v_dead;
    logic [2:0]        vcode;

    assign cz    = bus.controllable_zone;
    assign ileft = ~bus.iright;

    passageway_zone_step #(
        .NZONES(NZONES)
    ) u_zone_step (
        .zone              (zone),
        .mode              (mode),
        .controllable_zone (cz),
        .zone_next         (zone_next)
    );

    // cz[zone+1] only exists below the top zone
    always_comb begin
        cz_here = 1'b0;
        cz_up   = 1'b0;
        for (int k = 0; k < NZONES; k++) begin
            if (zone == ZW'(k)) begin
                cz_here = cz[k];
                if (k < NZONES - 1)
                    cz_up = cz[(k + 1) % NZONES];
            end
        end
    end

    always_comb begin
        mode_next = MODE_CLOSED;
        if (bus.controllable_open)
            mode_next = bus.controllable_doorstep ?
                        MODE_DOORSTEP : MODE_OPEN;
    end

    assign below_top = zone < ZW'(NZONES - 1);
    assign objective = notfirst & ~fault & ~err &
                       (zone == ZW'(TARGET));

    assign v_onehot = |(cz & (cz - NZONES'(1)));
    assign v_closed = (mode == MODE_CLOSED) &
                      bus.iup & bus.controllable_open;
    assign v_open   = (mode == MODE_OPEN) & ileft &
                      bus.controllable_doorstep & cz_here;
    assign v_door   = (mode == MODE_DOORSTEP) & below_top &
                      ((bus.iright & ~cz_up) |
                       (ileft & cz_up));
    assign v_dead   = (DEADLINE != 0) &&
                      (32'(steps) == 32'(DEADLINE)) &&
                      !objective;

    always_comb begin
        vcode = ERR_NONE;
        if (v_onehot)      vcode = ERR_ONEHOT;
        else if (v_closed) vcode = ERR_CLOSED;
        else if (v_open)   vcode = ERR_OPEN;
        else if (v_door)   vcode = ERR_DOORSTEP;
        else if (v_dead)   vcode = ERR_DEADLINE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            notfirst <= 1'b0;
            zone     <= '0;
            mode     <= MODE_CLOSED;
            fault    <= 1'b0;
            err      <= 1'b0;
            code     <= ERR_NONE;
            steps    <= '0;
        end else if (!notfirst) begin
            notfirst <= 1'b1;
        end else begin
            fault <= fault | bus.controllable_fault;
            mode  <= mode_next;
            zone  <= zone_next;
            if (steps != '1)
                steps <= steps + CW'(1);
            if (!err && vcode != ERR_NONE) begin
                err  <= 1'b1;
                code <= vcode;
            end
        end
    end

    assign bus.error     = err;
    assign bus.err_code  = code;
    assign bus.steps     = steps;
    assign bus.objective = objective;

endmodule

// File: tb/tb_passageway_monitor_n.sv
// Directed bench for passageway_monitor_n: default,
// deadline and small saturating configurations.
module tb_passageway_monitor_n;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    passageway_monitor_n_if #(.NZONES(5), .CW(8)) ia ();
    passageway_monitor_n_if #(.NZONES(5), .CW(8)) ib ();
    passageway_monitor_n_if #(.NZONES(3), .CW(3)) ic ();

    passageway_monitor_n dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia)
    );

    passageway_monitor_n #(
        .DEADLINE(6)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib)
    );

    passageway_monitor_n #(
        .NZONES(3),
        .CW(3)
    ) dut_c (
        .clk (clk),
        .rst (rst_c),
        .bus (ic)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h",
                     tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_a(input logic up, rt, op, ds, ft,
                         input logic [4:0] z);
        ia.iup                   = up;
        ia.iright                = rt;
        ia.controllable_open     = op;
        ia.controllable_doorstep = ds;
        ia.controllable_fault    = ft;
        ia.controllable_zone     = z;
    endtask

    task automatic reset_a();
        set_a(0, 0, 0, 0, 0, 5'b00000);
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        cyc();
    endtask

    initial begin
        set_a(0, 0, 0, 0, 0, 5'b00000);
        ib.iup = 0; ib.iright = 0;
        ib.controllable_open = 0;
        ib.controllable_doorstep = 0;
        ib.controllable_fault = 0;
        ib.controllable_zone = 5'b00001;
        ic.iup = 0; ic.iright = 0;
        ic.controllable_open = 0;
        ic.controllable_doorstep = 0;
        ic.controllable_fault = 0;
        ic.controllable_zone = 3'b001;
        @(negedge clk);
        cyc();

        // reset state and init edge
        check("rst_err", ia.error, 0);
        check("rst_code", ia.err_code, 0);
        check("rst_obj", ia.objective, 0);
        check("rst_steps", ia.steps, 0);
        rst_a = 1'b0;
        cyc();
        check("init_steps", ia.steps, 0);

        // clean walk 0..4
        for (int k = 0; k < 5; k++) begin
            set_a(0, 1, 1, 1, 0, 5'(1 << k));
            cyc();
            check("walk_zone", dut_a.zone, k);
            check("walk_code", ia.err_code, 0);
            check("walk_obj", ia.objective, k == 4);
        end
        check("walk_err", ia.error, 0);
        check("walk_steps", ia.steps, 5);

        // CLOSED violation then sticky code
        set_a(0, 1, 0, 0, 0, 5'b10000);
        cyc();
        check("to_closed", dut_a.mode, 0);
        check("top_obj", ia.objective, 1);
        set_a(1, 1, 1, 0, 0, 5'b10000);
        cyc();
        check("closed_err", ia.error, 1);
        check("closed_code", ia.err_code, 1);
        check("closed_obj", ia.objective, 0);
        set_a(0, 1, 1, 1, 0, 5'b10000);
        cyc();
        set_a(0, 1, 1, 1, 0, 5'b01000);
        cyc();
        check("down_zone", dut_a.zone, 3);
        cyc();
        check("sticky_code", ia.err_code, 1);

        // one-hot with iright=1: zone still advances
        reset_a();
        set_a(0, 1, 1, 1, 0, 5'b00001);
        cyc();
        set_a(0, 1, 1, 1, 0, 5'b00110);
        cyc();
        check("onehot_code", ia.err_code, 4);
        check("onehot_zone", dut_a.zone, 1);

        // one-hot beats a simultaneous DOORSTEP fault
        reset_a();
        set_a(0, 1, 1, 1, 0, 5'b00001);
        cyc();
        set_a(0, 0, 1, 1, 0, 5'b00110);
        cyc();
        check("onehot_prio", ia.err_code, 4);

        // plain DOORSTEP violation
        reset_a();
        set_a(0, 1, 1, 1, 0, 5'b00001);
        cyc();
        cyc();
        check("door_code", ia.err_code, 3);
        check("door_zone", dut_a.zone, 0);

        // OPEN violation
        reset_a();
        set_a(0, 1, 1, 0, 0, 5'b00001);
        cyc();
        check("to_open", dut_a.mode, 1);
        check("open_pre", ia.error, 0);
        set_a(0, 0, 1, 1, 0, 5'b00001);
        cyc();
        check("open_code", ia.err_code, 2);

        // fault blocks objective, then mid-run reset
        reset_a();
        for (int k = 0; k < 5; k++) begin
            set_a(0, 1, 1, 1, k == 3, 5'(1 << k));
            cyc();
        end
        check("fault_zone", dut_a.zone, 4);
        check("fault_obj", ia.objective, 0);
        check("fault_err", ia.error, 0);
        rst_a = 1'b1;
        set_a(0, 1, 0, 0, 0, 5'b00000);
        cyc();
        check("mrst_err", ia.error, 0);
        check("mrst_code", ia.err_code, 0);
        check("mrst_obj", ia.objective, 0);
        check("mrst_steps", ia.steps, 0);
        check("mrst_zone", dut_a.zone, 0);
        rst_a = 1'b0;
        set_a(1, 1, 1, 1, 0, 5'b00010);
        cyc();
        check("ign_mode", dut_a.mode, 0);
        check("ign_zone", dut_a.zone, 0);
        check("ign_err", ia.error, 0);
        check("ign_steps", ia.steps, 0);

        // deadline of 6 steps idling in zone 0
        rst_b = 1'b1;
        cyc();
        rst_b = 1'b0;
        cyc();
        cyc(6);
        check("dl_steps", ib.steps, 6);
        check("dl_pre", ib.error, 0);
        cyc();
        check("dl_code", ib.err_code, 5);
        check("dl_obj", ib.objective, 0);

        // 3-bit counter saturation and top-zone reach
        rst_c = 1'b1;
        cyc();
        rst_c = 1'b0;
        cyc();
        cyc(10);
        check("sat_steps", ic.steps, 7);
        ic.controllable_open = 1;
        ic.controllable_doorstep = 1;
        ic.iright = 1;
        cyc();
        ic.iright = 0;
        ic.controllable_zone = 3'b100;
        cyc();
        check("skip_zone", dut_c.zone, 0);
        check("skip_err", ic.error, 0);
        ic.iright = 1;
        ic.controllable_zone = 3'b010;
        cyc();
        check("c_zone1", dut_c.zone, 1);
        ic.controllable_zone = 3'b100;
        cyc();
        check("c_zone2", dut_c.zone, 2);
        check("c_obj", ic.objective, 1);
        check("c_steps", ic.steps, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/passageway_monitor_n.md
# passageway_monitor_n

Parametrised monitor for the passageway benchmark. It drives the SUT-facing observation model: each cycle it takes the tester inputs `iup`/`iright` and the SUT-reported `controllable_*` flags, tracks zone, door mode and fault, and raises a sticky `error` or `objective`. It generalises the fixed five-zone corridor monitor to `NZONES` zones with a configurable target zone. It adds a synchronous reset, a one-hot check on the zone flags, an optional step deadline, and an error-cause code.

## Interface
- `NZONES`, 5: number of zones; legal values are 2 or more.
- `TARGET`, NZONES-1: zone index that satisfies the objective.
- `DEADLINE`, 0: step limit; 0 disables the deadline rule.
- `CW`, 8: width of the step counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `iup`  in  1  tester input; `idown = ~iup`.
- `iright`  in  1  tester input; `ileft = ~iright`.
- `controllable_zone`  in  NZONES  SUT claims it is in zone k (bit k).
- `controllable_open`  in  1  SUT claims the door is open.
- `controllable_doorstep`  in  1  SUT claims it is at the doorstep.
- `controllable_fault`  in  1  SUT fault flag.
- `error`  out  1  sticky violation.
- `objective`  out  1  target reached cleanly.
- `err_code`  out  3  cause of the first violation; 0 means none.
- `steps`  out  CW  evaluated steps since init; saturates at all-ones.

## Operation
- **State registers:**
  - `notfirst`
  - `zone`, width `$clog2(NZONES)`
  - `mode`, 2 bits: CLOSED=0, OPEN=1, DOORSTEP=2
  - `fault`
  - `err`
  - `code`
  - `steps`
- **Reset:** `rst` high clears every register at the edge. All outputs are 0 in the following cycle.
- **Init edge:** the first edge with `notfirst==0` only sets `notfirst`. Everything else stays 0 and all inputs are ignored.
- **Regular edge** (`notfirst==1`):
  - `fault` is set sticky by `controllable_fault`.
  - `mode` next: `open & ~doorstep` gives OPEN; `open & doorstep` gives DOORSTEP; otherwise CLOSED.
  - `zone` next, priority lowest k first:
    - `controllable_zone[0]` gives 0.
    - Otherwise zone k (k≥1) is taken when `controllable_zone[k]` and either (`zone==k-1` and `mode==DOORSTEP`) or `zone==k+1`.
    - Zone NZONES-1 is reachable only from below.
    - If no rule fires, `zone` holds.
  - `steps` increments, saturating.
- **Violation rules** use the pre-edge registered `mode`/`zone` and the current inputs. Codes:
  - 4, ONEHOT: more than one bit of `controllable_zone` is set.
  - 1, CLOSED: `mode==CLOSED & iup & controllable_open`.
  - 2, OPEN: `mode==OPEN & ileft & controllable_doorstep & controllable_zone[zone]`.
  - 3, DOORSTEP: `mode==DOORSTEP`, `zone<NZONES-1`, and `(iright & ~cz[zone+1]) | (ileft & cz[zone+1])`.
  - 5, DEADLINE: `DEADLINE!=0 & steps==DEADLINE & ~objective`.
- **Simultaneous violations:** priority order is 4, then 1/2/3 (mutually exclusive by mode), then 5.
- **Stickiness:** `err` and `code` are written only while `err==0`. The first cause is kept until `rst`.
- **Objective:** `objective = notfirst & ~fault & ~err & (zone==TARGET)`.

## Timing
- `error`, `err_code`, `zone`, `mode` and `steps` reflect inputs sampled at edge n, starting in cycle n+1.
- `objective` is combinational from registers only. It adds no latency and has no input-to-output path.
- **Reset mid-run:** `rst` dominates all other inputs at that edge. The next edge is the init edge. The first evaluated step is the second edge after `rst` deasserts.
- **`steps` saturation:** at all-ones it holds. When `DEADLINE` exceeds `2^CW-1`, the deadline never fires.
- **Out-of-range zone index:** `cz[zone+1]` is never evaluated when `zone==NZONES-1`, so no out-of-range access occurs.

## Structure
- Package `passageway_pkg` holds:
  - the mode enum (CLOSED/OPEN/DOORSTEP)
  - the error-code constants (NONE=0, CLOSED=1, OPEN=2, DOORSTEP=3, ONEHOT=4, DEADLINE=5)
- Sub-module `passageway_zone_step` is combinational next-zone logic, parametrised by `NZONES`. Its inputs are `zone`, `mode` and `controllable_zone`; its output is `zone_next`. The top module holds all registers, the violation rules and the counter.

## Test plan
All scenarios use defaults (NZONES=5, TARGET=4, DEADLINE=0) unless stated.
- **Clean walk:** reset, then init edge. Each step asserts `open=1`, `doorstep=1`, `iright=1`, and the single zone flag k for k=0..4. Expect `zone` 0→4 and `objective=1` after the final step. `error=0` and `err_code=0` throughout.
- **CLOSED violation:** with `mode==CLOSED`, apply `iup=1`, `controllable_open=1`. Expect `error=1`, `err_code=1` next cycle. A later DOORSTEP violation leaves the code at 1.
- **One-hot violation:** apply `controllable_zone=5'b00110` while in DOORSTEP with zone 0 and `iright=1`. Expect `err_code=4` (priority over 3) and `zone` becomes 1.
- **Deadline:** DEADLINE=6 and the SUT idles in zone 0. Expect `err_code=5` in the cycle after the edge where `steps==6`. `objective` stays 0.
- **Fault and reset:** a `controllable_fault` pulse in zone 3, then reach zone 4. Expect `objective=0`. Then assert `rst` for one cycle: all outputs are 0, and the first post-reset edge ignores a `controllable_zone[1]` pulse.
- **Saturation:** NZONES=3, CW=3, idle for 10 steps. Expect `steps` to hold at 7, and zone 2 is unreachable from zone 0 without passing zone 1.
